// File: rtl/sdram_rd_pkg.sv
// Shared types, default parameters and configuration helpers for the HPS
// f2h_sdram0 burst reader.
package sdram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned SDRAM_DATA_W     = 64;
  localparam int unsigned SDRAM_ADDR_W     = 29;
  localparam int unsigned SDRAM_BURST_W    = 8;
  localparam int unsigned SDRAM_MAX_BURST  = 16;
  localparam int unsigned SDRAM_FIFO_DEPTH = 64;
  localparam int unsigned SDRAM_LEN_W      = 24;

  localparam int unsigned FIFO_CNT_W = $clog2(SDRAM_FIFO_DEPTH) + 1;

  function automatic int unsigned fifo_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // A burst must always fit in an empty buffer, or the credit check deadlocks.
  function automatic bit burst_cfg_legal(input int unsigned max_burst,
                                         input int unsigned depth);
    return (max_burst >= 1) && (max_burst <= 128) && (max_burst <= depth) &&
           ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/sdram_rd_fifo.sv
// First-word fall-through read-data buffer with occupancy count; head data
// reads as zero while the buffer is empty.
module sdram_rd_fifo
  import sdram_rd_pkg::*;
#(
  parameter int unsigned DATA_W     = SDRAM_DATA_W,
  parameter int unsigned FIFO_DEPTH = SDRAM_FIFO_DEPTH,
  parameter int unsigned CNT_W      = fifo_cnt_w(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(FIFO_DEPTH)) || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are meaningful, so a reset here would only add fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign valid_o = (count_q != '0);
  assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/sdram_burst_reader.sv
// Avalon-MM burst read master for HPS f2h_sdram0 replaying a contiguous block
// on an Avalon-ST source. Define SDRAM_RD_CHECKSUM_EN to add rd_checksum.
module sdram_burst_reader
  import sdram_rd_pkg::*;
#(
  parameter int unsigned DATA_W     = SDRAM_DATA_W,
  parameter int unsigned ADDR_W     = SDRAM_ADDR_W,
  parameter int unsigned BURST_W    = SDRAM_BURST_W,
  parameter int unsigned MAX_BURST  = SDRAM_MAX_BURST,
  parameter int unsigned FIFO_DEPTH = SDRAM_FIFO_DEPTH,
  parameter int unsigned LEN_W      = SDRAM_LEN_W
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic               cfg_start,
  input  logic [ADDR_W-1:0]  cfg_base_addr,
  input  logic [LEN_W-1:0]   cfg_len_words,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  avm_address,
  output logic [BURST_W-1:0] avm_burstcount,
  output logic               avm_read,
  input  logic               avm_waitrequest,
  input  logic [DATA_W-1:0]  avm_readdata,
  input  logic               avm_readdatavalid,
  output logic [DATA_W-1:0]  st_data,
  output logic               st_valid,
  input  logic               st_ready,
  output logic               st_last
`ifdef SDRAM_RD_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]  rd_checksum
`endif
);

  localparam int unsigned CNT_W = fifo_cnt_w(FIFO_DEPTH);
  localparam int unsigned CRD_W = CNT_W + 1;

  if (!burst_cfg_legal(MAX_BURST, FIFO_DEPTH)) begin : g_bad_cfg
    $error("sdram_burst_reader: MAX_BURST/FIFO_DEPTH combination is illegal");
  end

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   req_left_q, req_left_d;
  logic [LEN_W-1:0]   pop_left_q, pop_left_d;
  logic [CNT_W-1:0]   outst_q, outst_d;
  logic               avm_read_q, avm_read_d;
  logic [ADDR_W-1:0]  avm_addr_q, avm_addr_d;
  logic [BURST_W-1:0] avm_burst_q, avm_burst_d;
  logic               err_spurious_q;

  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_valid;
  logic [DATA_W-1:0]  fifo_data;
  logic               accept, push, pop, launch;
  logic [BURST_W-1:0] beats;
  logic [CRD_W-1:0]   used, free;

  assign accept = avm_read_q && !avm_waitrequest;
  assign push   = avm_readdatavalid && (outst_q != '0);
  assign pop    = fifo_valid && st_ready;
  assign beats  = (req_left_q > LEN_W'(MAX_BURST)) ? BURST_W'(MAX_BURST)
                                                   : BURST_W'(req_left_q);

  // Outstanding beats are reserved at launch, so a stalled command already
  // holds its buffer space; a same-cycle pop frees a slot before the check.
  assign used   = CRD_W'(fifo_count) + CRD_W'(outst_q) - CRD_W'(pop);
  assign free   = CRD_W'(FIFO_DEPTH) - used;
  assign launch = (state_q == ISSUE) && (req_left_q != '0) &&
                  (!avm_read_q || accept) && (free >= CRD_W'(beats));

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    req_left_d  = req_left_q;
    pop_left_d  = pop_left_q - LEN_W'(pop);
    outst_d     = outst_q - CNT_W'(push);
    avm_read_d  = avm_read_q && !accept;
    avm_addr_d  = avm_addr_q;
    avm_burst_d = avm_burst_q;

    if (launch) begin
      avm_read_d  = 1'b1;
      avm_addr_d  = addr_q;
      avm_burst_d = beats;
      addr_d      = addr_q + ADDR_W'(beats);
      req_left_d  = req_left_q - LEN_W'(beats);
      outst_d     = outst_d + CNT_W'(beats);
    end

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          addr_d     = cfg_base_addr;
          req_left_d = cfg_len_words;
          pop_left_d = cfg_len_words;
          state_d    = (cfg_len_words == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if ((req_left_q == '0) && (!avm_read_q || accept)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop_left_q == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      req_left_q     <= '0;
      pop_left_q     <= '0;
      outst_q        <= '0;
      avm_read_q     <= 1'b0;
      avm_addr_q     <= '0;
      avm_burst_q    <= '0;
      err_spurious_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      req_left_q  <= req_left_d;
      pop_left_q  <= pop_left_d;
      outst_q     <= outst_d;
      avm_read_q  <= avm_read_d;
      avm_addr_q  <= avm_addr_d;
      avm_burst_q <= avm_burst_d;
      if (avm_readdatavalid && (outst_q == '0)) err_spurious_q <= 1'b1;
    end
  end

  sdram_rd_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) u_fifo (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .push_i  (push),
    .wdata_i (avm_readdata),
    .pop_i   (pop),
    .rdata_o (fifo_data),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

`ifdef SDRAM_RD_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      csum_q <= '0;
    end else if ((state_q == IDLE) && cfg_start) begin
      csum_q <= '0;
    end else if (pop) begin
      csum_q <= csum_q ^ fifo_data;
    end
  end

  assign rd_checksum = csum_q;
`endif

  assign busy           = (state_q == ISSUE) || (state_q == DRAIN);
  assign done           = (state_q == DONE);
  assign avm_read       = avm_read_q;
  assign avm_address    = avm_addr_q;
  assign avm_burstcount = avm_burst_q;
  assign st_valid       = fifo_valid;
  assign st_data        = fifo_data;
  assign st_last        = fifo_valid && (pop_left_q == LEN_W'(1));

endmodule

// File: tb/tb_sdram_burst_reader.sv
// Directed bench for sdram_burst_reader: an SDRAM responder model returns
// address-derived data, and each test task checks its own scenario.
module tb_sdram_burst_reader;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [28:0] cfg_base_addr = '0;
  logic [23:0] cfg_len_words = '0;
  logic        busy, done;
  logic [28:0] avm_address;
  logic [7:0]  avm_burstcount;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [63:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic [63:0] st_data;
  logic        st_valid;
  logic        st_ready = 1'b1;
  logic        st_last;
`ifdef SDRAM_RD_CHECKSUM_EN
  logic [63:0] rd_checksum;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0] got_q[$];
  logic        last_q[$];
  logic [28:0] cmd_a[$];
  logic [7:0]  cmd_b[$];
  logic [28:0] pend_q[$];
  int          done_cnt = 0;
  bit          read_seen = 1'b0;
  bit          spur_req = 1'b0;
  bit          data_mode = 1'b0;
  logic [28:0] csum_base = '0;

  sdram_burst_reader dut (
    .clk_clk           (clk_clk),
    .reset_reset_n     (reset_reset_n),
    .cfg_start         (cfg_start),
    .cfg_base_addr     (cfg_base_addr),
    .cfg_len_words     (cfg_len_words),
    .busy              (busy),
    .done              (done),
    .avm_address       (avm_address),
    .avm_burstcount    (avm_burstcount),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .st_data           (st_data),
    .st_valid          (st_valid),
    .st_ready          (st_ready),
    .st_last           (st_last)
`ifdef SDRAM_RD_CHECKSUM_EN
    ,
    .rd_checksum       (rd_checksum)
`endif
  );

  always #5 clk_clk = ~clk_clk;

  function automatic logic [63:0] exp_data(input logic [28:0] a);
    if (data_mode) return 64'd1 << (a - csum_base);
    return 64'hC0DE_0000_0000_0000 | {35'd0, a};
  endfunction

  // SDRAM model: logs commands accepted at the next edge, returns one beat
  // per cycle starting the cycle after acceptance.
  always @(negedge clk_clk) begin
    if (!reset_reset_n) begin
      pend_q.delete();
      avm_readdatavalid = 1'b0;
    end else begin
      if (spur_req) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = 64'hBAD0_BAD0_BAD0_BAD0;
        spur_req          = 1'b0;
      end else if (pend_q.size() > 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = exp_data(pend_q.pop_front());
      end else begin
        avm_readdatavalid = 1'b0;
      end
      if (avm_read && !avm_waitrequest) begin
        cmd_a.push_back(avm_address);
        cmd_b.push_back(avm_burstcount);
        for (int i = 0; i < int'(avm_burstcount); i++)
          pend_q.push_back(avm_address + 29'(i));
      end
    end
  end

  always @(negedge clk_clk) begin
    if (reset_reset_n) begin
      if (st_valid && st_ready) begin
        got_q.push_back(st_data);
        last_q.push_back(st_last);
      end
      if (done) done_cnt++;
      if (avm_read) read_seen = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic clear_logs();
    got_q.delete(); last_q.delete(); cmd_a.delete(); cmd_b.delete();
    done_cnt = 0; read_seen = 1'b0;
  endtask

  task automatic start_xfer(input logic [28:0] b, input logic [23:0] l);
    tick();
    cfg_base_addr = b; cfg_len_words = l; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int c = 0; c < budget && done_cnt == 0; c++) tick();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    #1;
    n_assert++;
    if ({busy, done, avm_read, avm_address, avm_burstcount, st_valid, st_data, st_last} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: busy=%b done=%b read=%b addr=%h bc=%h valid=%b data=%h last=%b, expected all 0",
        busy, done, avm_read, avm_address, avm_burstcount, st_valid, st_data, st_last);
    end
    repeat (3) tick();
    reset_reset_n = 1'b1;
    tick();
    n_assert++;
    if ({busy, done, avm_read, st_valid} !== 4'b0) begin
      n_fail++; $display("FAIL reset_idle: busy=%b done=%b read=%b valid=%b, expected 0000", busy, done, avm_read, st_valid);
    end
  endtask

  task automatic test_basic();
    logic [28:0] ea [3] = '{29'h100, 29'h110, 29'h120};
    logic [7:0]  eb [3] = '{8'd16, 8'd16, 8'd8};
    clear_logs();
    start_xfer(29'h100, 24'd40);
    n_assert++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: busy=%b, expected 1", busy); end
    wait_done(500);
    n_assert++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done: %0d done pulses, expected 1", done_cnt); end
    n_assert++;
    if (cmd_a.size() !== 3) begin n_fail++; $display("FAIL basic_ncmd: %0d commands, expected 3", cmd_a.size()); end
    for (int i = 0; i < 3 && i < cmd_a.size(); i++) begin
      n_assert++;
      if (cmd_a[i] !== ea[i] || cmd_b[i] !== eb[i]) begin
        n_fail++; $display("FAIL basic_cmd[%0d]: (%h,%0d), expected (%h,%0d)", i, cmd_a[i], cmd_b[i], ea[i], eb[i]);
      end
    end
    n_assert++;
    if (got_q.size() !== 40) begin n_fail++; $display("FAIL basic_nwords: %0d words, expected 40", got_q.size()); end
    for (int i = 0; i < 40 && i < got_q.size(); i++) begin
      n_assert++;
      if (got_q[i] !== exp_data(29'h100 + 29'(i)) || last_q[i] !== (i == 39)) begin
        n_fail++; $display("FAIL basic_word[%0d]: data=%h last=%b, expected data=%h last=%b",
          i, got_q[i], last_q[i], exp_data(29'h100 + 29'(i)), (i == 39));
      end
    end
  endtask

  task automatic test_zero_len();
    clear_logs();
    start_xfer(29'h200, 24'd0);
    n_assert++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_done: done=%b busy=%b, expected done=1 busy=0", done, busy);
    end
    tick();
    n_assert++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL zero_pulse: done=%b, expected 0", done); end
    repeat (5) tick();
    n_assert++;
    if (read_seen !== 1'b0 || done_cnt !== 1) begin
      n_fail++; $display("FAIL zero_noread: read_seen=%b done_cnt=%0d, expected 0 and 1", read_seen, done_cnt);
    end
  endtask

  task automatic test_backpressure();
    int sum;
    clear_logs();
    st_ready = 1'b0;
    start_xfer(29'h2000, 24'd200);
    repeat (150) tick();
    sum = 0;
    foreach (cmd_b[i]) sum += int'(cmd_b[i]);
    n_assert++;
    if (sum !== 64 || avm_read !== 1'b0 || st_valid !== 1'b1 || got_q.size() !== 0) begin
      n_fail++; $display("FAIL bp_stall: requested=%0d read=%b valid=%b popped=%0d, expected 64 0 1 0",
        sum, avm_read, st_valid, got_q.size());
    end
    st_ready = 1'b1;
    wait_done(3000);
    n_assert++;
    if (done_cnt !== 1 || cmd_a.size() !== 13) begin
      n_fail++; $display("FAIL bp_done: done_cnt=%0d commands=%0d, expected 1 and 13", done_cnt, cmd_a.size());
    end
    for (int k = 0; k < 13 && k < cmd_a.size(); k++) begin
      n_assert++;
      if (cmd_a[k] !== 29'h2000 + 29'(16 * k) || cmd_b[k] !== ((k == 12) ? 8'd8 : 8'd16)) begin
        n_fail++; $display("FAIL bp_cmd[%0d]: (%h,%0d), expected (%h,%0d)", k, cmd_a[k], cmd_b[k],
          29'h2000 + 29'(16 * k), (k == 12) ? 8 : 16);
      end
    end
    n_assert++;
    if (got_q.size() !== 200) begin n_fail++; $display("FAIL bp_nwords: %0d words, expected 200", got_q.size()); end
    for (int i = 0; i < 200 && i < got_q.size(); i++) begin
      n_assert++;
      if (got_q[i] !== exp_data(29'h2000 + 29'(i)) || last_q[i] !== (i == 199)) begin
        n_fail++; $display("FAIL bp_word[%0d]: data=%h last=%b, expected data=%h last=%b",
          i, got_q[i], last_q[i], exp_data(29'h2000 + 29'(i)), (i == 199));
      end
    end
  endtask

  task automatic test_waitrequest();
    int c;
    clear_logs();
    start_xfer(29'h3000, 24'd32);
    for (c = 0; c < 100 && !(cmd_a.size() == 1 && avm_read && avm_address == 29'h3010); c++) tick();
    n_assert++;
    if (c >= 100) begin n_fail++; $display("FAIL wr_second_cmd: second command not presented within 100 cycles"); end
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_assert++;
      if (avm_read !== 1'b1 || avm_address !== 29'h3010 || avm_burstcount !== 8'd16 || cmd_a.size() !== 1) begin
        n_fail++; $display("FAIL wr_hold[%0d]: read=%b addr=%h bc=%0d accepted=%0d, expected 1 3010 16 1",
          i, avm_read, avm_address, avm_burstcount, cmd_a.size());
      end
    end
    avm_waitrequest = 1'b0;
    @(negedge clk_clk);
    #1;
    n_assert++;
    if (cmd_a.size() !== 2) begin n_fail++; $display("FAIL wr_accept: %0d accepted, expected 2 on the 6th cycle", cmd_a.size()); end
    wait_done(500);
    n_assert++;
    if (done_cnt !== 1 || got_q.size() !== 32 || last_q[31] !== 1'b1) begin
      n_fail++; $display("FAIL wr_done: done_cnt=%0d words=%0d, expected 1 and 32 with last", done_cnt, got_q.size());
    end
  endtask

  task automatic test_start_while_busy();
    clear_logs();
    start_xfer(29'h500, 24'd20);
    repeat (3) tick();
    cfg_base_addr = 29'h900; cfg_len_words = 24'd5; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    wait_done(500);
    repeat (20) tick();
    n_assert++;
    if (done_cnt !== 1 || busy !== 1'b0 || cmd_a.size() !== 2) begin
      n_fail++; $display("FAIL busy_ignore: done_cnt=%0d busy=%b commands=%0d, expected 1 0 2", done_cnt, busy, cmd_a.size());
    end
    n_assert++;
    if (got_q.size() !== 20) begin n_fail++; $display("FAIL busy_nwords: %0d words, expected 20", got_q.size()); end
    for (int i = 0; i < 20 && i < got_q.size(); i++) begin
      n_assert++;
      if (got_q[i] !== exp_data(29'h500 + 29'(i))) begin
        n_fail++; $display("FAIL busy_word[%0d]: data=%h, expected %h", i, got_q[i], exp_data(29'h500 + 29'(i)));
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    start_xfer(29'h40, 24'd64);
    for (int c = 0; c < 200 && got_q.size() < 3; c++) tick();
    reset_reset_n = 1'b0;
    #1;
    n_assert++;
    if ({busy, done, avm_read, avm_address, avm_burstcount, st_valid, st_data, st_last} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: busy=%b read=%b addr=%h bc=%h valid=%b data=%h last=%b, expected all 0",
        busy, avm_read, avm_address, avm_burstcount, st_valid, st_data, st_last);
    end
    repeat (3) tick();
    reset_reset_n = 1'b1;
    clear_logs();
    start_xfer(29'h1FFF_FFF8, 24'd24);
    wait_done(500);
    n_assert++;
    if (done_cnt !== 1 || cmd_a.size() !== 2) begin
      n_fail++; $display("FAIL midreset_rerun: done_cnt=%0d commands=%0d, expected 1 and 2", done_cnt, cmd_a.size());
    end
    n_assert++;
    if (cmd_a.size() == 2 && (cmd_a[1] !== 29'h0000_0008 || cmd_b[1] !== 8'd8)) begin
      n_fail++; $display("FAIL addr_wrap: second command (%h,%0d), expected (00000008,8)", cmd_a[1], cmd_b[1]);
    end
    n_assert++;
    if (got_q.size() !== 24) begin n_fail++; $display("FAIL midreset_nwords: %0d words, expected 24", got_q.size()); end
    for (int i = 0; i < 24 && i < got_q.size(); i++) begin
      n_assert++;
      if (got_q[i] !== exp_data(29'h1FFF_FFF8 + 29'(i)) || last_q[i] !== (i == 23)) begin
        n_fail++; $display("FAIL midreset_word[%0d]: data=%h last=%b, expected data=%h last=%b",
          i, got_q[i], last_q[i], exp_data(29'h1FFF_FFF8 + 29'(i)), (i == 23));
      end
    end
  endtask

  task automatic test_spurious();
    clear_logs();
    n_assert++;
    if (dut.err_spurious_q !== 1'b0) begin n_fail++; $display("FAIL spur_clean: err_spurious=%b, expected 0", dut.err_spurious_q); end
    spur_req = 1'b1;
    repeat (4) tick();
    n_assert++;
    if (dut.err_spurious_q !== 1'b1 || st_valid !== 1'b0 || got_q.size() !== 0) begin
      n_fail++; $display("FAIL spur_drop: err_spurious=%b valid=%b popped=%0d, expected 1 0 0",
        dut.err_spurious_q, st_valid, got_q.size());
    end
  endtask

`ifdef SDRAM_RD_CHECKSUM_EN
  task automatic test_checksum();
    int c;
    clear_logs();
    data_mode = 1'b1;
    csum_base = 29'h77;
    start_xfer(29'h77, 24'd4);
    for (c = 0; c < 200 && done !== 1'b1; c++) tick();
    n_assert++;
    if (done !== 1'b1 || rd_checksum !== 64'hF) begin
      n_fail++; $display("FAIL csum_done: done=%b rd_checksum=%h, expected 1 and f", done, rd_checksum);
    end
    repeat (3) tick();
    n_assert++;
    if (rd_checksum !== 64'hF) begin n_fail++; $display("FAIL csum_hold: rd_checksum=%h, expected f", rd_checksum); end
    data_mode = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_waitrequest();
    test_start_while_busy();
    test_reset_mid();
    test_spurious();
`ifdef SDRAM_RD_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
